// File: rtl/ram_access_pkg.sv
// rtl/ram_access_pkg.sv - Constants, state encoding and burst types for ram_access_ctrl.
// RAM_ACCESS_READBACK_EN adds the verify states.
package ram_access_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;

  typedef logic [3:0] len_t;
  typedef logic [3:0] word_addr_t;

`ifdef RAM_ACCESS_READBACK_EN
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, VFY_ADDR, VFY_DATA} state_e;
`else
  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_e;
`endif
endpackage

// File: rtl/ram_access_beat_ctr.sv
// rtl/ram_access_beat_ctr.sv - Burst word pointer and remaining-beat counter.
// The pointer wraps modulo 16.
module ram_access_beat_ctr
  import ram_access_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  word_addr_t addr_i,
  input  len_t       len_i,
  input  logic       step_i,
  output word_addr_t cur_o,
  output word_addr_t cur_next_o,
  output len_t       cnt_o,
  output logic       last_o
);
  word_addr_t cur_q, cur_d;
  len_t       cnt_q, cnt_d;

  always_comb begin
    cur_d = cur_q;
    cnt_d = cnt_q;
    if (load_i) begin
      cur_d = addr_i;
      cnt_d = len_i;
    end else if (step_i) begin
      cur_d = cur_q + 4'd1;
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end

  assign cur_o      = cur_q;
  assign cur_next_o = cur_q + 4'd1;
  assign cnt_o      = cnt_q;
  assign last_o     = (cnt_q == 4'd0);
endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - Burst read/write initiator for the 16x8 registered-address RAM.
// Define RAM_ACCESS_READBACK_EN to re-read each write burst and flag mismatches on err.
module ram_access_ctrl
  import ram_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e     state_q;
  logic       done_q;
  word_addr_t cur, cur_next;
  len_t       cnt;
  logic       last;
  logic       req_fire, wr_fire, rd_fire;
  logic       ctr_load, ctr_step;
  word_addr_t ctr_addr;
  len_t       ctr_len;
  logic       unused_bits;

  assign req_fire    = req_ready && req_valid;
  assign wr_fire     = (state_q == WR) && wr_valid;
  assign rd_fire     = (state_q == RD_DATA) && rd_ready;
  assign unused_bits = ^{req_addr[ADDR_W-1], cnt};

`ifdef RAM_ACCESS_READBACK_EN
  logic [DATA_W-1:0] shadow_q [DEPTH];
  word_addr_t        start_q;
  len_t              len_q;
  len_t              beat_idx;
  logic              err_q;

  // Beat index is the same for the write pass and the verify pass.
  assign beat_idx = len_q - cnt;
  assign ctr_load = req_fire || (wr_fire && last);
  assign ctr_addr = req_fire ? req_addr[3:0] : start_q;
  assign ctr_len  = req_fire ? req_len : len_q;
  assign ctr_step = wr_fire || rd_fire || (state_q == VFY_DATA);

  always_ff @(posedge clk) begin
    if (wr_fire) shadow_q[beat_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_fire) begin
        start_q <= req_addr[3:0];
        len_q   <= req_len;
        err_q   <= 1'b0;
      end else if (state_q == VFY_DATA && ram_data_out != shadow_q[beat_idx]) begin
        err_q <= 1'b1;
      end
    end
  end
  assign err = err_q;
`else
  assign ctr_load = req_fire;
  assign ctr_addr = req_addr[3:0];
  assign ctr_len  = req_len;
  assign ctr_step = wr_fire || rd_fire;
  assign err      = 1'b0;
`endif

  ram_access_beat_ctr u_beat_ctr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ctr_load),
    .addr_i     (ctr_addr),
    .len_i      (ctr_len),
    .step_i     (ctr_step),
    .cur_o      (cur),
    .cur_next_o (cur_next),
    .cnt_o      (cnt),
    .last_o     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:    if (req_fire) state_q <= req_write ? WR : RD_ADDR;
        WR:      if (wr_fire && last) begin
`ifdef RAM_ACCESS_READBACK_EN
                   state_q <= VFY_ADDR;
`else
                   state_q <= IDLE;
                   done_q  <= 1'b1;
`endif
                 end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: if (rd_fire && last) begin
                   state_q <= IDLE;
                   done_q  <= 1'b1;
                 end
`ifdef RAM_ACCESS_READBACK_EN
        VFY_ADDR: state_q <= VFY_DATA;
        VFY_DATA: if (last) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                  end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pre-advancing the address on an accepted read beat hides the RAM's address register.
  always_comb begin
    req_ready        = (state_q == IDLE) && !rst;
    wr_ready         = (state_q == WR);
    rd_valid         = (state_q == RD_DATA);
    rd_data          = '0;
    ram_data_in      = '0;
    ram_address      = '0;
    ram_write_enable = 1'b0;
    case (state_q)
      WR: begin
        ram_address      = {{(ADDR_W-4){1'b0}}, cur};
        ram_data_in      = wr_data;
        ram_write_enable = wr_valid;
      end
      RD_ADDR: ram_address = {{(ADDR_W-4){1'b0}}, cur};
      RD_DATA: begin
        rd_data     = ram_data_out;
        ram_address = {{(ADDR_W-4){1'b0}}, (rd_ready ? cur_next : cur)};
      end
`ifdef RAM_ACCESS_READBACK_EN
      VFY_ADDR: ram_address = {{(ADDR_W-4){1'b0}}, cur};
      VFY_DATA: ram_address = {{(ADDR_W-4){1'b0}}, cur_next};
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - Self-checking bench for ram_access_ctrl with a registered-address RAM model.
// Covers RAM_ACCESS_READBACK_EN when defined.
module tb_ram_access_ctrl;
  import ram_access_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_enable;
  logic [DATA_W-1:0] ram_data_out;
  logic              busy, done, err;

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ram_mem   [DEPTH];
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] sb [$];
  logic              flip_en = 1'b0;
  logic              flip_now;

`ifdef RAM_ACCESS_READBACK_EN
  localparam int DONE_BOUND = 40;
`else
  localparam int DONE_BOUND = 1;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address[3:0]] <= ram_data_in;
    ram_addr_q <= ram_address;
  end
  assign flip_now     = flip_en && busy && !wr_ready && !rd_valid && (ram_addr_q[3:0] == 4'd6);
  assign ram_data_out = ram_mem[ram_addr_q[3:0]] ^ (flip_now ? 8'h01 : 8'h00);

  ram_access_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .ram_data_in      (ram_data_in),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic w, input logic [4:0] a, input logic [3:0] l);
    int t;
    logic [3:0] ix;
    t = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    do begin @(negedge clk); t++; end while (!req_ready && t < 20);
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!w) begin
      for (int i = 0; i <= int'(l); i++) begin
        ix = a[3:0] + 4'(i);
        sb.push_back(model_mem[ix]);
      end
    end
  endtask

  task automatic write_beats(input logic [4:0] a, input logic [3:0] l, input logic [7:0] seed,
                             input logic [15:0] gaps);
    logic [3:0] ix;
    for (int i = 0; i <= int'(l); i++) begin
      ix = a[3:0] + 4'(i);
      if (gaps[i]) begin
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_gap_we", 32'(ram_write_enable), 32'd0);
        chk("wr_gap_ready", 32'(wr_ready), 32'd1);
        @(posedge clk); #1;
      end
      wr_valid = 1'b1;
      wr_data  = seed + 8'(i);
      @(negedge clk);
      chk("wr_we", 32'(ram_write_enable), 32'd1);
      chk("wr_addr", 32'(ram_address), 32'({1'b0, ix}));
      chk("wr_data", 32'(ram_data_in), 32'(wr_data));
      @(posedge clk); #1;
      model_mem[ix] = wr_data;
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_beats(input logic [4:0] a, input logic [3:0] l, input logic stall,
                            output logic [7:0] first);
    logic [3:0] cur;
    int got, cyc;
    cur = a[3:0]; got = 0; cyc = 0; first = '0;
    @(negedge clk);
    chk("rd_addr_valid", 32'(rd_valid), 32'd0);
    chk("rd_addr_ram_address", 32'(ram_address), 32'({1'b0, cur}));
    @(posedge clk); #1;
    while (got <= int'(l) && cyc < 64) begin
      rd_ready = stall ? cyc[0] : 1'b1;
      @(negedge clk);
      chk("rd_valid", 32'(rd_valid), 32'd1);
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL sb_underflow: got beat %0h expected none", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(sb[0]));
        if (rd_ready) begin
          chk("rd_addr_adv", 32'(ram_address), 32'({1'b0, cur + 4'd1}));
          if (got == 0) first = rd_data;
          void'(sb.pop_front());
          got++;
          cur = cur + 4'd1;
        end else begin
          chk("rd_addr_hold", 32'(ram_address), 32'({1'b0, cur}));
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("rd_beats", 32'(got), 32'(l) + 32'd1);
  endtask

  task automatic expect_done(input string nm, input logic exp_err);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < DONE_BOUND);
    chk(nm, 32'(done), 32'd1);
    chk("err_at_done", 32'(err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [3:0] len;
    logic [7:0] seed;
    logic       stall;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] first;
    logic       done_seen;

    vecs[0] = '{1'b1, 5'd18, 4'd2, 8'h20, 1'b0, 8'h20};
    vecs[1] = '{1'b0, 5'd3,  4'd0, 8'h00, 1'b0, 8'h21};
    vecs[2] = '{1'b1, 5'd15, 4'd0, 8'h5A, 1'b0, 8'h5A};
    vecs[3] = '{1'b0, 5'd31, 4'd2, 8'h00, 1'b0, 8'h5A};
    vecs[4] = '{1'b1, 5'd9,  4'd5, 8'hE0, 1'b0, 8'hE0};
    vecs[5] = '{1'b0, 5'd12, 4'd3, 8'h00, 1'b1, 8'hE3};
    vecs[6] = '{1'b0, 5'd4,  4'd0, 8'h00, 1'b0, 8'h22};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Single write then single read of word 3.
    issue(1'b1, 5'd3, 4'd0);
    write_beats(5'd3, 4'd0, 8'hA5, 16'h0);
    expect_done("single_wr_done", 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 5'd3, 4'd0);
    read_beats(5'd3, 4'd0, 1'b0, first);
    chk("single_rd_data", 32'(first), 32'hA5);
    expect_done("single_rd_done", 1'b0);

    // Fill every word so later checks have known contents.
    issue(1'b1, 5'd0, 4'd15);
    write_beats(5'd0, 4'd15, 8'h10, 16'h0);
    expect_done("fill_done", 1'b0);

    // Burst wrapping 14,15,0,1.
    issue(1'b1, 5'd14, 4'd3);
    write_beats(5'd14, 4'd3, 8'h01, 16'h0);
    expect_done("wrap_wr_done", 1'b0);
    chk("wrap_mem14", 32'(ram_mem[14]), 32'h01);
    chk("wrap_mem15", 32'(ram_mem[15]), 32'h02);
    chk("wrap_mem0",  32'(ram_mem[0]),  32'h03);
    chk("wrap_mem1",  32'(ram_mem[1]),  32'h04);
    issue(1'b0, 5'd14, 4'd3);
    read_beats(5'd14, 4'd3, 1'b0, first);
    chk("wrap_rd_first", 32'(first), 32'h01);
    expect_done("wrap_rd_done", 1'b0);

    // 16-beat read with rd_ready toggling.
    issue(1'b0, 5'd5, 4'd15);
    read_beats(5'd5, 4'd15, 1'b1, first);
    expect_done("stall_rd_done", 1'b0);

    // Write with wr_valid gaps before beats 1 and 3.
    issue(1'b1, 5'd8, 4'd3);
    write_beats(5'd8, 4'd3, 8'h80, 16'h000A);
    expect_done("gap_wr_done", 1'b0);
    for (int i = 0; i < 4; i++) chk("gap_mem", 32'(ram_mem[8+i]), 32'h80 + 32'(i));

`ifndef RAM_ACCESS_READBACK_EN
    // New request accepted while done is high.
    issue(1'b1, 5'd6, 4'd0);
    write_beats(5'd6, 4'd0, 8'h66, 16'h0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd6; req_len = 4'd0;
    sb.push_back(model_mem[6]);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    read_beats(5'd6, 4'd0, 1'b0, first);
    chk("b2b_rd_first", 32'(first), 32'h66);
    expect_done("b2b_rd_done", 1'b0);
`endif

    for (int k = 0; k < 7; k++) begin
      issue(vecs[k].wr, vecs[k].addr, vecs[k].len);
      if (vecs[k].wr) begin
        write_beats(vecs[k].addr, vecs[k].len, vecs[k].seed, 16'h0);
        expect_done("tbl_wr_done", 1'b0);
        chk("tbl_wr_word", 32'(ram_mem[vecs[k].addr[3:0]]), 32'(vecs[k].exp));
      end else begin
        read_beats(vecs[k].addr, vecs[k].len, vecs[k].stall, first);
        expect_done("tbl_rd_done", 1'b0);
        chk("tbl_rd_first", 32'(first), 32'(vecs[k].exp));
      end
    end

    // Reset after 3 beats of an 8-beat write.
    issue(1'b1, 5'd0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hC0 + 8'(i);
      @(posedge clk); #1;
      model_mem[i] = wr_data;
    end
    wr_data = 8'hC3;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(ram_write_enable), 32'd0);
    chk("mid_rst_ram_address", 32'(ram_address), 32'd0);
    chk("mid_rst_ram_data_in", 32'(ram_data_in), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);
    chk("mid_rst_req_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) chk("mid_rst_mem", 32'(ram_mem[i]), 32'(model_mem[i]));

`ifdef RAM_ACCESS_READBACK_EN
    // Corrupt the verify read of word 6 only.
    flip_en = 1'b1;
    issue(1'b1, 5'd4, 4'd3);
    write_beats(5'd4, 4'd3, 8'h70, 16'h0);
    chk("vfy_no_rd_valid", 32'(rd_valid), 32'd0);
    expect_done("vfy_done", 1'b1);
    flip_en = 1'b0;
    issue(1'b0, 5'd6, 4'd0);
    chk("vfy_err_cleared", 32'(err), 32'd0);
    read_beats(5'd6, 4'd0, 1'b0, first);
    chk("vfy_rd_first", 32'(first), 32'h72);
    expect_done("vfy_rd_done", 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
